prescale_ratio_ctrl: RTL and testbench
======================================

// Module: prescale_ratio_ctrl
// PURPOSE
//  Owns the divide ratio driven to the UART RX clock divider. Accepts prescale-change requests from system control,
//  validates them (32/16/8/4), maps each to its divide ratio and applies the change only on a divider period
//  boundary. Gates the divider for one cycle and acks after a settle window. Sits between SYS_CTRL/regfile and ClkDiv.
// PARAMETERS
//  DIV_W          8    width of div_ratio
//  PRESC_W        6    width of prescale codes
//  SETTLE_CYCLES  4    cycles held in SETTLE after apply (>=1)
//  TIMEOUT        255  max cycles waiting for div_tick before abort (>=1)
// PORTS
//  CLK           in   1        system clock (single clock domain)
//  RST           in   1        synchronous reset, active-low
//  cfg_req       in   1        request; sampled only in IDLE
//  cfg_prescale  in   PRESC_W  requested prescale, valid with cfg_req
//  cfg_ack       out  1        1-cycle pulse: request completed (applied or already current)
//  cfg_err       out  1        1-cycle pulse: invalid prescale or tick timeout
//  cfg_busy      out  1        high while not IDLE
//  div_tick      in   1        divider period-boundary strobe from ClkDiv
//  div_ratio     out  DIV_W    ratio to ClkDiv
//  div_en        out  1        divider enable
//  cur_prescale  out  PRESC_W  prescale currently applied
// BEHAVIOUR
//  - Reset (RST=0 at CLK edge): state IDLE, div_ratio=1, cur_prescale=32, div_en=1, cfg_ack=0, cfg_err=0, cfg_busy=0.
//    Reset mid-operation aborts the transaction and reverts to these values (prescale 32), no ack/err.
//  - Mapping: 32->1, 16->2, 8->4, 4->8; any other code invalid. All outputs registered.
//  - IDLE: cfg_req=1 latches cfg_prescale -> CHECK. Requests while busy ignored, not queued.
//  - CHECK (1 cycle): invalid -> cfg_err pulse, IDLE; equal to cur_prescale -> cfg_ack pulse, IDLE, no divider
//    disturbance; else -> WAIT_TICK, wait counter cleared.
//  - WAIT_TICK: div_tick=1 -> APPLY. Counter increments each cycle without tick; on reaching TIMEOUT -> cfg_err
//    pulse, IDLE, div_ratio/cur_prescale unchanged. div_tick outside WAIT_TICK ignored.
//  - APPLY (1 cycle): div_en=0; div_ratio and cur_prescale load new values at end of cycle -> SETTLE.
//  - SETTLE: div_en=1, counts SETTLE_CYCLES cycles -> IDLE with cfg_ack pulse in first IDLE cycle.
//  - Timing (req sampled cycle 0): CHECK c1; WAIT_TICK c2; tick in c2 -> APPLY c3; SETTLE c4..c(3+S);
//    ack/busy=0 in c(4+S). Invalid/same-value: err/ack in c2 with busy=0.
//  - cfg_ack and cfg_err never both high. cfg_req high in the ack/err cycle is accepted (state is IDLE).
//  - cfg_busy = (state != IDLE), registered with state.
// STRUCTURE
//  - Shared package/include: prescale code constants (PRESC_32/16/8/4), ratio constants (RATIO_1/2/4/8),
//    state encoding (IDLE, CHECK, WAIT_TICK, APPLY, SETTLE).
//  - Sub-module prescale_ratio_lut: combinational prescale -> {valid, ratio}; FSM and counters in top.
// TESTING
//  1. Reset then idle -> div_ratio=1, cur_prescale=32, div_en=1, busy/ack/err=0.
//  2. req prescale=8 c0, div_tick c2 -> div_en=0 only c3; div_ratio=4 from c4; ack single pulse c8 (S=4).
//  3. req prescale=12 -> err pulse c2, div_ratio stays 1, no div_en drop.
//  4. req prescale=32 while current 32 -> ack c2, div_en never drops.
//  5. req prescale=16, no div_tick for TIMEOUT=255 cycles -> err pulse, div_ratio stays 1; second req during
//     WAIT_TICK ignored.
//  6. RST=0 during SETTLE after switch to 4 -> next cycle div_ratio=1, cur_prescale=32, busy=0, no ack.

Source files
------------

// File: rtl/prescale_ratio_ctrl_pkg.sv
// Shared constants for the UART RX prescale/divide-ratio controller:
// legal prescale codes, their divide ratios, and the controller state encoding.
package prescale_ratio_ctrl_pkg;

  // Legal prescale codes
  localparam int unsigned PRESC_32 = 32;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_4  = 4;

  // Divide ratios driven to ClkDiv for each code
  localparam int unsigned RATIO_1 = 1;
  localparam int unsigned RATIO_2 = 2;
  localparam int unsigned RATIO_4 = 4;
  localparam int unsigned RATIO_8 = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWaitTick,
    StApply,
    StSettle
  } state_e;

endpackage

// File: rtl/prescale_ratio_ctrl_lut.sv
// Combinational prescale-code to divide-ratio lookup.
// Ports:
//   prescale  in   requested prescale code
//   valid     out  code is one of 32/16/8/4
//   ratio     out  divide ratio for the code (RATIO_1 when invalid)
module prescale_ratio_lut
  import prescale_ratio_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned PRESC_W = 6
) (
  input  logic [PRESC_W-1:0] prescale,
  output logic               valid,
  output logic [DIV_W-1:0]   ratio
);

  always_comb begin
    valid = 1'b1;
    ratio = DIV_W'(RATIO_1);
    case (prescale)
      PRESC_W'(PRESC_32): ratio = DIV_W'(RATIO_1);
      PRESC_W'(PRESC_16): ratio = DIV_W'(RATIO_2);
      PRESC_W'(PRESC_8):  ratio = DIV_W'(RATIO_4);
      PRESC_W'(PRESC_4):  ratio = DIV_W'(RATIO_8);
      default:            valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/prescale_ratio_ctrl.sv
// Owns the divide ratio driven to the UART RX clock divider. Validates prescale
// change requests, applies them only on a divider period boundary (div_tick),
// gates the divider for the apply cycle and acks after a settle window.
// Ports:
//   CLK, RST      clock, synchronous active-low reset
//   cfg_req       request (sampled only when idle), cfg_prescale requested code
//   cfg_ack       1-cycle pulse: request completed (applied or already current)
//   cfg_err       1-cycle pulse: invalid code or tick timeout
//   cfg_busy      high while a request is in progress
//   div_tick      divider period-boundary strobe
//   div_ratio     ratio to ClkDiv, div_en divider enable
//   cur_prescale  prescale currently applied
module prescale_ratio_ctrl
  import prescale_ratio_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned PRESC_W       = 6,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_req,
  input  logic [PRESC_W-1:0] cfg_prescale,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic               cfg_busy,
  input  logic               div_tick,
  output logic [DIV_W-1:0]   div_ratio,
  output logic               div_en,
  output logic [PRESC_W-1:0] cur_prescale
);

  // One counter serves both the tick timeout and the settle window
  localparam int unsigned CntMax = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PRESC_W-1:0] req_q, req_d;
  logic [PRESC_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0]   ratio_q, ratio_d;
  logic               en_q, en_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               lut_valid;
  logic [DIV_W-1:0]   lut_ratio;

  prescale_ratio_lut #(
    .DIV_W   (DIV_W),
    .PRESC_W (PRESC_W)
  ) u_lut (
    .prescale (req_q),
    .valid    (lut_valid),
    .ratio    (lut_ratio)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cur_d   = cur_q;
    ratio_d = ratio_q;
    en_d    = 1'b1;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_req) begin
          req_d   = cfg_prescale;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!lut_valid) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (req_q == cur_q) begin
          // Already current: ack without touching the divider
          ack_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StWaitTick;
        end
      end
      StWaitTick: begin
        if (div_tick) begin
          en_d    = 1'b0;  // divider gated during the apply cycle
          state_d = StApply;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StApply: begin
        ratio_d = lut_ratio;
        cur_d   = req_q;
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          ack_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= PRESC_W'(PRESC_32);
      cur_q   <= PRESC_W'(PRESC_32);
      ratio_q <= DIV_W'(RATIO_1);
      en_q    <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cur_q   <= cur_d;
      ratio_q <= ratio_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign cfg_ack      = ack_q;
  assign cfg_err      = err_q;
  assign cfg_busy     = busy_q;
  assign div_ratio    = ratio_q;
  assign div_en       = en_q;
  assign cur_prescale = cur_q;

endmodule

// File: tb/tb_prescale_ratio_ctrl.sv
// Directed bench for prescale_ratio_ctrl with hand-computed expected values.
module tb_prescale_ratio_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cfg_req = 1'b0;
  logic [5:0] cfg_prescale = '0;
  logic       cfg_ack, cfg_err, cfg_busy;
  logic       div_tick = 1'b0;
  logic [7:0] div_ratio;
  logic       div_en;
  logic [5:0] cur_prescale;

  int n_checks = 0;
  int n_fail   = 0;

  prescale_ratio_ctrl #(
    .DIV_W         (8),
    .PRESC_W       (6),
    .SETTLE_CYCLES (4),
    .TIMEOUT       (255)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cfg_req      (cfg_req),
    .cfg_prescale (cfg_prescale),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .cfg_busy     (cfg_busy),
    .div_tick     (div_tick),
    .div_ratio    (div_ratio),
    .div_en       (div_en),
    .cur_prescale (cur_prescale)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [7:0] ratio, input logic [5:0] cur);
    check_eq({tag, ".ratio"}, 32'(div_ratio), 32'(ratio));
    check_eq({tag, ".cur"}, 32'(cur_prescale), 32'(cur));
    check_eq({tag, ".en"}, 32'(div_en), 32'd1);
    check_eq({tag, ".busy"}, 32'(cfg_busy), 32'd0);
    check_eq({tag, ".ack"}, 32'(cfg_ack), 32'd0);
    check_eq({tag, ".err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int cyc;
    bit en_drop, ack_seen;

    // 1. reset
    RST = 1'b0;
    step();
    step();
    RST = 1'b1;
    step();
    check_idle("reset", 8'd1, 6'd32);

    // 3. invalid code 12: err in c2, no divider disturbance
    cfg_req = 1'b1; cfg_prescale = 6'd12;        // c0
    step(); cfg_req = 1'b0;                      // c1
    check_eq("inv.busy_c1", 32'(cfg_busy), 32'd1);
    check_eq("inv.en_c1", 32'(div_en), 32'd1);
    step();                                      // c2
    check_eq("inv.err_c2", 32'(cfg_err), 32'd1);
    check_eq("inv.ack_c2", 32'(cfg_ack), 32'd0);
    check_eq("inv.busy_c2", 32'(cfg_busy), 32'd0);
    check_eq("inv.ratio_c2", 32'(div_ratio), 32'd1);
    step();                                      // c3
    check_idle("inv.c3", 8'd1, 6'd32);

    // 4. same value 32: ack in c2; a new req in that cycle is accepted (code 12 -> err c4)
    cfg_req = 1'b1; cfg_prescale = 6'd32;        // c0
    step(); cfg_req = 1'b0;                      // c1
    check_eq("same.en_c1", 32'(div_en), 32'd1);
    step();                                      // c2
    check_eq("same.ack_c2", 32'(cfg_ack), 32'd1);
    check_eq("same.err_c2", 32'(cfg_err), 32'd0);
    check_eq("same.busy_c2", 32'(cfg_busy), 32'd0);
    check_eq("same.en_c2", 32'(div_en), 32'd1);
    cfg_req = 1'b1; cfg_prescale = 6'd12;
    step(); cfg_req = 1'b0;                      // c3
    check_eq("back2back.ack_c3", 32'(cfg_ack), 32'd0);
    check_eq("back2back.busy_c3", 32'(cfg_busy), 32'd1);
    step();                                      // c4
    check_eq("back2back.err_c4", 32'(cfg_err), 32'd1);
    step();
    check_idle("back2back.c5", 8'd1, 6'd32);

    // 5. code 16 with no tick: err after TIMEOUT tickless cycles; extra req ignored
    cfg_req = 1'b1; cfg_prescale = 6'd16;        // c0
    step(); cfg_req = 1'b0;                      // c1
    step();                                      // c2
    cyc = 2;
    check_eq("tmo.busy_c2", 32'(cfg_busy), 32'd1);
    step(); step();                              // c4
    cyc = 4;
    cfg_req = 1'b1; cfg_prescale = 6'd4;         // ignored while busy
    step(); cfg_req = 1'b0;
    cyc = 5;
    en_drop = 1'b0; ack_seen = 1'b0;
    while (!cfg_err && cyc < 400) begin
      if (!div_en) en_drop = 1'b1;
      if (cfg_ack) ack_seen = 1'b1;
      step();
      cyc++;
    end
    check_eq("tmo.err_cycle", 32'(cyc), 32'd257);
    check_eq("tmo.en_drop", 32'(en_drop), 32'd0);
    check_eq("tmo.ack_seen", 32'(ack_seen), 32'd0);
    check_eq("tmo.ratio", 32'(div_ratio), 32'd1);
    check_eq("tmo.cur", 32'(cur_prescale), 32'd32);
    check_eq("tmo.busy", 32'(cfg_busy), 32'd0);
    step();
    check_idle("tmo.after", 8'd1, 6'd32);

    // 2. code 8 with tick in c2: div_en low only c3, ratio 4 from c4, ack c8
    cfg_req = 1'b1; cfg_prescale = 6'd8;         // c0
    step(); cfg_req = 1'b0;                      // c1
    step(); div_tick = 1'b1;                     // c2
    check_eq("sw.en_c2", 32'(div_en), 32'd1);
    check_eq("sw.ratio_c2", 32'(div_ratio), 32'd1);
    step(); div_tick = 1'b0;                     // c3
    check_eq("sw.en_c3", 32'(div_en), 32'd0);
    check_eq("sw.ratio_c3", 32'(div_ratio), 32'd1);
    step();                                      // c4
    check_eq("sw.en_c4", 32'(div_en), 32'd1);
    check_eq("sw.ratio_c4", 32'(div_ratio), 32'd4);
    check_eq("sw.cur_c4", 32'(cur_prescale), 32'd8);
    for (int c = 5; c <= 7; c++) begin
      step();
      check_eq($sformatf("sw.ack_c%0d", c), 32'(cfg_ack), 32'd0);
      check_eq($sformatf("sw.busy_c%0d", c), 32'(cfg_busy), 32'd1);
    end
    step();                                      // c8
    check_eq("sw.ack_c8", 32'(cfg_ack), 32'd1);
    check_eq("sw.busy_c8", 32'(cfg_busy), 32'd0);
    step();                                      // c9
    check_idle("sw.c9", 8'd4, 6'd8);

    // same value 8 now current: ack c2
    cfg_req = 1'b1; cfg_prescale = 6'd8;
    step(); cfg_req = 1'b0;
    step();
    check_eq("same8.ack_c2", 32'(cfg_ack), 32'd1);
    check_eq("same8.ratio", 32'(div_ratio), 32'd4);
    step();

    // 6. switch to 4, reset during SETTLE reverts with no ack
    cfg_req = 1'b1; cfg_prescale = 6'd4;         // c0
    step(); cfg_req = 1'b0;                      // c1
    step(); div_tick = 1'b1;                     // c2
    step(); div_tick = 1'b0;                     // c3
    step();                                      // c4 (SETTLE)
    check_eq("rst.ratio_c4", 32'(div_ratio), 32'd8);
    check_eq("rst.cur_c4", 32'(cur_prescale), 32'd4);
    step();                                      // c5
    RST = 1'b0;
    step();                                      // c6
    check_idle("rst.c6", 8'd1, 6'd32);
    RST = 1'b1;
    ack_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (cfg_ack || cfg_busy) ack_seen = 1'b1;
    end
    check_eq("rst.no_ack", 32'(ack_seen), 32'd0);
    check_idle("rst.final", 8'd1, 6'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Ack and err are mutually exclusive at all times
  always @(negedge CLK) begin
    if (RST && cfg_ack && cfg_err) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_err_excl: got ack=1 err=1 expected not both");
    end
  end

endmodule
